gold_coin_ctrl: RTL and testbench

- Drives the gold-coin sprite: owns its on-screen position, maps the raster pixel to sprite-relative offsets, and runs the collect/respawn life cycle.
- Outputs offsetX, offsetY, InsideRectangle and gold_ena, which feed the gold bitmap drawer directly.
- Inputs are the VGA raster (pixelX, pixelY, startOfFrame) and the player/gold collision flag from the collision detector.
- Emits a one-cycle score pulse to the score counter.

---
 rtl/gold_coin_ctrl.sv | 113 +++++++++++
 tb/tb_gold_coin_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gold_coin_ctrl.sv
// Gold-coin sprite controller: tracks the coin's screen position, maps the raster
// to sprite-relative offsets, and runs the collect / hide / respawn cycle.
module gold_coin_ctrl #(
  parameter int          OBJECT_WIDTH_X = 32,
  parameter int          OBJECT_HEIGHT_Y = 32,
  parameter int          INIT_X = 288,
  parameter int          INIT_Y = 224,
  parameter int          RESPAWN_FRAMES = 120,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        collision,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic        gold_ena,
  output logic        score_pulse,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY
);

  typedef enum logic {ST_VISIBLE, ST_WAIT} state_t;

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [7:0]  r_cnt;
  logic [10:0] r_tlx;
  logic [10:0] r_tly;
  logic [10:0] r_offx;
  logic [10:0] r_offy;
  logic        r_inside;
  logic        r_ena;
  logic        r_score;

  logic [15:0] w_lfsr_next;
  logic [10:0] w_right;
  logic [10:0] w_bottom;
  logic        w_inside;

  // Galois right-shift, taps 16'hB400; only stepped on startOfFrame below.
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  assign w_right  = r_tlx + 11'(OBJECT_WIDTH_X);
  assign w_bottom = r_tly + 11'(OBJECT_HEIGHT_Y);
  assign w_inside = (pixelX >= r_tlx) && (pixelX < w_right) &&
                    (pixelY >= r_tly) && (pixelY < w_bottom);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_offx   <= '0;
      r_offy   <= '0;
      r_inside <= 1'b0;
    end else begin
      r_inside <= w_inside;
      r_offx   <= w_inside ? (pixelX - r_tlx) : 11'd0;
      r_offy   <= w_inside ? (pixelY - r_tly) : 11'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_VISIBLE;
      r_lfsr  <= LFSR_SEED;
      r_cnt   <= '0;
      r_tlx   <= 11'(INIT_X);
      r_tly   <= 11'(INIT_Y);
      r_ena   <= 1'b0;
      r_score <= 1'b0;
    end else begin
      r_score <= 1'b0;
      if (startOfFrame) begin
        r_lfsr <= w_lfsr_next;
      end
      case (r_state)
        ST_VISIBLE: begin
          // A collision on a frame boundary wins; that frame is not counted.
          if (collision) begin
            r_score <= 1'b1;
            r_ena   <= 1'b1;
            r_cnt   <= 8'(RESPAWN_FRAMES);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (startOfFrame) begin
            if (r_cnt > 8'd1) begin
              r_cnt <= r_cnt - 8'd1;
            end else begin
              r_state <= ST_VISIBLE;
              r_ena   <= 1'b0;
              r_tlx   <= 11'd32 + {2'b00, w_lfsr_next[7:0], 1'b0};
              r_tly   <= 11'd32 + {3'b000, w_lfsr_next[15:8]};
            end
          end
        end
        default: r_state <= ST_VISIBLE;
      endcase
    end
  end

  assign offsetX         = r_offx;
  assign offsetY         = r_offy;
  assign InsideRectangle = r_inside;
  assign gold_ena        = r_ena;
  assign score_pulse     = r_score;
  assign topLeftX        = r_tlx;
  assign topLeftY        = r_tly;

endmodule

// File: tb/tb_gold_coin_ctrl.sv
// Bench for gold_coin_ctrl: directed steps plus randomized respawn traffic,
// compared cycle by cycle with a frame-level model of the coin's life cycle.
module tb_gold_coin_ctrl;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int RF = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame, collision;
  logic [10:0] offsetX, offsetY, topLeftX, topLeftY;
  logic        InsideRectangle, gold_ena, score_pulse;

  int checks = 0;
  int failures = 0;

  // model state
  bit          m_hidden;
  int          m_left, m_x, m_y, respawns, scores;
  int unsigned m_lfsr;
  int          e_offx, e_offy;
  bit          e_in, e_score;

  gold_coin_ctrl #(
    .OBJECT_WIDTH_X(W), .OBJECT_HEIGHT_Y(H), .INIT_X(288), .INIT_Y(224),
    .RESPAWN_FRAMES(RF), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .collision(collision),
    .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
    .gold_ena(gold_ena), .score_pulse(score_pulse),
    .topLeftX(topLeftX), .topLeftY(topLeftY)
  );

  always #5 clk = ~clk;

  function automatic int unsigned lfsr_adv(input int unsigned v);
    return (v & 1) ? ((v >> 1) ^ 32'hB400) : (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hidden = 0; m_left = 0; m_x = 288; m_y = 224; m_lfsr = 32'hACE1;
    e_offx = 0; e_offy = 0; e_in = 0; e_score = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_offx"}, 16'(offsetX), 16'd0);
    chk({tag, "_offy"}, 16'(offsetY), 16'd0);
    chk({tag, "_in"}, 16'(InsideRectangle), 16'd0);
    chk({tag, "_ena"}, 16'(gold_ena), 16'd0);
    chk({tag, "_score"}, 16'(score_pulse), 16'd0);
    chk({tag, "_tlx"}, 16'(topLeftX), 16'd288);
    chk({tag, "_tly"}, 16'(topLeftY), 16'd224);
    chk({tag, "_lfsr"}, dut.r_lfsr, 16'hACE1);
  endtask

  task automatic chk_all();
    chk("offsetX", 16'(offsetX), 16'(e_offx));
    chk("offsetY", 16'(offsetY), 16'(e_offy));
    chk("inside", 16'(InsideRectangle), 16'(e_in));
    chk("gold_ena", 16'(gold_ena), 16'(m_hidden));
    chk("score", 16'(score_pulse), 16'(e_score));
    chk("topLeftX", 16'(topLeftX), 16'(m_x));
    chk("topLeftY", 16'(topLeftY), 16'(m_y));
    chk("lfsr", dut.r_lfsr, 16'(m_lfsr));
    chk("lfsr_nonzero", 16'(dut.r_lfsr != 16'd0), 16'd1);
  endtask

  // One clock: drive inputs, predict from the frame-level rules, check after the edge.
  task automatic step(input int px, input int py, input bit sof, input bit col);
    int unsigned nl;
    bit in_box, respawned;
    pixelX = 11'(px); pixelY = 11'(py); startOfFrame = sof; collision = col;
    in_box = (px >= m_x) && (px < m_x + W) && (py >= m_y) && (py < m_y + H);
    e_in = in_box;
    e_offx = in_box ? px - m_x : 0;
    e_offy = in_box ? py - m_y : 0;
    e_score = 0;
    respawned = 0;
    nl = sof ? lfsr_adv(m_lfsr) : m_lfsr;
    if (!m_hidden) begin
      if (col) begin m_hidden = 1; m_left = RF; e_score = 1; end
    end else if (sof) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_hidden = 0;
        m_x = 32 + 2 * int'(nl % 256);
        m_y = 32 + int'(nl / 256);
        respawned = 1;
        respawns++;
      end
    end
    m_lfsr = nl;
    @(posedge clk); #1;
    chk_all();
    if (score_pulse === 1'b1) scores++;
    if (respawned) begin
      chk("x_range", 16'(topLeftX >= 11'd32 && topLeftX <= 11'd542), 16'd1);
      chk("y_range", 16'(topLeftY >= 11'd32 && topLeftY <= 11'd287), 16'd1);
    end
  endtask

  initial begin
    int px, py, sx, sy;
    reset = 1'b1; pixelX = '0; pixelY = '0; startOfFrame = 0; collision = 0;
    respawns = 0; scores = 0;
    model_reset();
    #1;
    chk_reset_vals("rst0");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // geometry around the initial box
    step(288, 224, 0, 0);
    chk("corner_tl_off", {5'd0, offsetX}, 16'd0);
    step(319, 255, 0, 0);
    chk("corner_br_offx", 16'(offsetX), 16'd31);
    chk("corner_br_offy", 16'(offsetY), 16'd31);
    step(320, 224, 0, 0);
    chk("right_edge_in", 16'(InsideRectangle), 16'd0);
    step(287, 230, 0, 0);
    step(300, 256, 0, 0);
    step(300, 240, 0, 0);

    // asynchronous reset mid-line
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(posedge clk); #1;
    chk_reset_vals("rst_held");
    #3 reset = 1'b0;
    model_reset();

    // collision held for 5 cycles: one score pulse
    scores = 0;
    repeat (5) step(10, 10, 0, 1);
    step(10, 10, 0, 0);
    chk("one_score", 16'(scores), 16'd1);
    chk("hidden_after_hit", 16'(gold_ena), 16'd1);

    // three frames hidden, respawn on the third
    step(10, 10, 1, 1);
    step(10, 10, 0, 0);
    chk("hidden_f1", 16'(gold_ena), 16'd1);
    step(10, 10, 1, 0);
    step(10, 10, 0, 0);
    chk("hidden_f2", 16'(gold_ena), 16'd1);
    chk("tlx_hold", 16'(topLeftX), 16'd288);
    step(10, 10, 1, 0);
    chk("visible_f3", 16'(gold_ena), 16'd0);
    chk("respawn_x", 16'(topLeftX), 16'(32 + 2 * (m_lfsr & 255)));
    chk("respawn_y", 16'(topLeftY), 16'(32 + (m_lfsr >> 8)));

    // collision coincident with startOfFrame: that frame is not counted
    step(m_x + 5, m_y + 5, 1, 1);
    chk("coinc_hidden", 16'(gold_ena), 16'd1);
    repeat (2) step(0, 0, 1, 0);
    chk("coinc_still_hidden", 16'(gold_ena), 16'd1);
    step(0, 0, 1, 0);
    chk("coinc_visible", 16'(gold_ena), 16'd0);

    // randomized traffic until 1000 respawns
    respawns = 0;
    for (int i = 0; i < 60000 && respawns < 1000; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        px = m_x + int'($urandom_range(0, 40)) - 4;
        py = m_y + int'($urandom_range(0, 40)) - 4;
      end else begin
        px = int'($urandom_range(0, 799));
        py = int'($urandom_range(0, 524));
      end
      sx = ($urandom_range(0, 2) == 0) ? 1 : 0;
      sy = ($urandom_range(0, 1) == 0) ? 1 : 0;
      step(px, py, sx[0], sy[0]);
    end
    chk("respawn_budget", 16'(respawns >= 1000), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
